// File: rtl/conv_enc_213.sv
// ---------------------------------------------------------------------------
// conv_enc_213 -- framed (2,1,3) convolutional encoder.
//
// Takes source bits on a valid/ready handshake. Each bit is encoded with
// generators G0 (Tx[1]) and G1 (Tx[0]). After every FRAME_LEN data bits the
// encoder appends M zero tail bits, so every frame ends with the trellis
// back in state 0. That lets the downstream Viterbi decoder trace back from
// state 0.
//
// Handshake: a bit is accepted on a rising edge where in_valid && in_ready.
// in_ready is registered. While in_ready is low, in_valid and in_bit are
// ignored. Each output symbol is registered and appears one cycle after its
// bit is accepted (or its tail cycle), qualified by tx_valid.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   in_bit    in   source data bit
//   in_valid  in   in_bit is valid
//   in_ready  out  encoder accepts in_bit this cycle
//   err_mask  in   [N-1:0] XORed into valid symbols (CONV_ENC_ERR_INJECT_EN only)
//   Tx        out  [N-1:0] encoded symbol (to decoder Rx)
//   tx_valid  out  Tx holds a new symbol
//   tx_sof    out  Tx is the symbol of data bit 0 of a frame
//   tx_eof    out  Tx is the last tail symbol of a frame
//   busy      out  a frame is in progress (first accept .. tx_eof inclusive)
//   state_dbg out  current FSM state (0 = DATA, 1 = TAIL)
//
// Optional feature macro: CONV_ENC_ERR_INJECT_EN
//   Adds the err_mask input. The mask only corrupts the emitted symbol,
//   never the encoder shift register.
// ---------------------------------------------------------------------------
module conv_enc_213 #(
  parameter int         N         = 2,
  parameter int         M         = 3,
  parameter logic [M:0] G0        = 4'b1111,
  parameter logic [M:0] G1        = 4'b1011,
  parameter int         FRAME_LEN = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_bit,
  input  logic         in_valid,
`ifdef CONV_ENC_ERR_INJECT_EN
  input  logic [N-1:0] err_mask,
`endif
  output logic         in_ready,
  output logic [N-1:0] Tx,
  output logic         tx_valid,
  output logic         tx_sof,
  output logic         tx_eof,
  output logic         busy,
  output logic         state_dbg
);

  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int TW = (M > 1) ? $clog2(M) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TAIL_LAST = TW'(M - 1);

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_TAIL = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [M-1:0]    s_q, s_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]   tail_cnt_q, tail_cnt_d;
  logic            in_ready_q, in_ready_d;
  logic [N-1:0]    tx_q, tx_d;
  logic            tx_valid_q, tx_valid_d;
  logic            tx_sof_q, tx_sof_d;
  logic            tx_eof_q, tx_eof_d;
  logic            busy_q, busy_d;

  logic            accept;
  logic            u;
  logic [M:0]      v;
  logic [N-1:0]    enc;
  logic [N-1:0]    sym;

  // Tail cycles feed zeros; s[M-1] is the most recent previous bit.
  assign accept = (state_q == ST_DATA) && in_valid && in_ready_q;
  assign u      = (state_q == ST_DATA) ? in_bit : 1'b0;
  assign v      = {u, s_q};
  assign enc    = {^(v & G0), ^(v & G1)};

`ifdef CONV_ENC_ERR_INJECT_EN
  assign sym = enc ^ err_mask;
`else
  assign sym = enc;
`endif

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    bit_cnt_d  = bit_cnt_q;
    tail_cnt_d = tail_cnt_q;
    in_ready_d = in_ready_q;
    tx_d       = '0;
    tx_valid_d = 1'b0;
    tx_sof_d   = 1'b0;
    tx_eof_d   = 1'b0;
    busy_d     = busy_q;

    case (state_q)
      ST_DATA: begin
        in_ready_d = 1'b1;
        // A stall inside a frame (bit_cnt != 0) keeps busy asserted.
        busy_d     = (bit_cnt_q != '0);
        if (accept) begin
          s_d        = v[M:1];
          tx_d       = sym;
          tx_valid_d = 1'b1;
          tx_sof_d   = (bit_cnt_q == '0);
          busy_d     = 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d  = '0;
            tail_cnt_d = '0;
            in_ready_d = 1'b0;
            state_d    = ST_TAIL;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      ST_TAIL: begin
        in_ready_d = 1'b0;
        busy_d     = 1'b1;
        s_d        = v[M:1];
        tx_d       = sym;
        tx_valid_d = 1'b1;
        tail_cnt_d = tail_cnt_q + TW'(1);
        if (tail_cnt_q == TAIL_LAST) begin
          tail_cnt_d = '0;
          tx_eof_d   = 1'b1;
          in_ready_d = 1'b1;
          state_d    = ST_DATA;
        end
      end
      default: begin
        state_d = ST_DATA;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_DATA;
      s_q        <= '0;
      bit_cnt_q  <= '0;
      tail_cnt_q <= '0;
      in_ready_q <= 1'b0;
      tx_q       <= '0;
      tx_valid_q <= 1'b0;
      tx_sof_q   <= 1'b0;
      tx_eof_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      bit_cnt_q  <= bit_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      in_ready_q <= in_ready_d;
      tx_q       <= tx_d;
      tx_valid_q <= tx_valid_d;
      tx_sof_q   <= tx_sof_d;
      tx_eof_q   <= tx_eof_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign Tx        = tx_q;
  assign tx_valid  = tx_valid_q;
  assign tx_sof    = tx_sof_q;
  assign tx_eof    = tx_eof_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_conv_enc_213.sv
// ---------------------------------------------------------------------------
// tb_conv_enc_213 -- self-checking bench for conv_enc_213 (FRAME_LEN = 4).
// The expected symbol stream is computed from the generator polynomials as
// a convolution over each frame's bit sequence (data bits then M zeros).
// Build with +define+CONV_ENC_ERR_INJECT_EN to cover the error-inject path.
// ---------------------------------------------------------------------------
module tb_conv_enc_213;
  localparam int FL = 4;
  localparam int M  = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] err_mask = 2'b00;
  logic       in_ready;
  logic [1:0] Tx;
  logic       tx_valid, tx_sof, tx_eof, busy, state_dbg;

  // Generator taps: bit M multiplies the current bit, bit 0 the bit M steps back.
  logic [3:0] g0 = 4'b1111;
  logic [3:0] g1 = 4'b1011;

  int         total = 0;
  int         bad = 0;
  logic [3:0] exp_q[$];          // {symbol[1:0], sof, eof}
  logic [3:0] mon_e;
  int         gap_cnt = 0;       // idle cycles while busy
  int         run_cnt = 0;
  int         max_run = 0;
  bit         hold_valid = 1'b0;
  int         low;

  conv_enc_213 #(.FRAME_LEN(FL)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_bit   (in_bit),
    .in_valid (in_valid),
`ifdef CONV_ENC_ERR_INJECT_EN
    .err_mask (err_mask),
`endif
    .in_ready (in_ready),
    .Tx       (Tx),
    .tx_valid (tx_valid),
    .tx_sof   (tx_sof),
    .tx_eof   (tx_eof),
    .busy     (busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Symbol j of a frame: Tx[g] = XOR over k=0..M of G[M-k] & u[j-k],
  // where u is the frame's data bits followed by M zeros, and u[<0] = 0.
  function automatic void push_frame(input logic [FL-1:0] b, input int nsym,
                                     input int mask_idx, input logic [1:0] mask);
    for (int j = 0; j < FL + M; j++) begin
      logic [1:0] sym;
      sym = 2'b00;
      for (int k = 0; k <= M; k++) begin
        int   idx;
        logic ub;
        idx = j - k;
        ub  = (idx >= 0 && idx < FL) ? b[idx] : 1'b0;
        if (g0[M-k] && ub) sym[1] = ~sym[1];
        if (g1[M-k] && ub) sym[0] = ~sym[0];
      end
      if (j == mask_idx) sym = sym ^ mask;
      if (j < nsym) exp_q.push_back({sym, j == 0, j == FL + M - 1});
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (tx_valid) begin
        run_cnt++;
        if (run_cnt > max_run) max_run = run_cnt;
        check_val("queue_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_val("tx",  32'(Tx),     32'(mon_e[3:2]));
          check_val("sof", 32'(tx_sof), 32'(mon_e[1]));
          check_val("eof", 32'(tx_eof), 32'(mon_e[0]));
        end
        if (tx_eof) check_val("busy_at_eof", 32'(busy), 1);
      end else begin
        run_cnt = 0;
        check_val("idle_outputs", {28'd0, Tx, tx_sof, tx_eof}, 0);
        if (busy) gap_cnt++;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_bit(input logic b, input logic [1:0] m);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clock);
      if (in_ready) begin
        in_valid = 1'b1;
        in_bit   = b;
        err_mask = m;
        done     = 1'b1;
      end else begin
        in_valid = hold_valid;
        in_bit   = 1'($urandom_range(0, 1));
        err_mask = 2'b00;
      end
    end
    check_val("send_accepted", 32'(done), 1);
    @(posedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      in_valid = 1'b0;
      in_bit   = 1'($urandom_range(0, 1));
      err_mask = 2'b00;
      check_val("stall_busy", 32'(busy), 1);
    end
  endtask

  task automatic send_frame(input logic [FL-1:0] b, input int stall_pos, input int stall_len,
                            input int mask_idx, input logic [1:0] mask);
    for (int i = 0; i < FL; i++) begin
      send_bit(b[i], (i == mask_idx) ? mask : 2'b00);
      if (i == stall_pos) idle(stall_len);
    end
  endtask

  // Drops in_valid and counts cycles until in_ready returns.
  task automatic finish_frame(output int lowc);
    bit done;
    done = 1'b0;
    lowc = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clock);
      in_valid = 1'b0;
      err_mask = 2'b00;
      if (in_ready) done = 1'b1;
      else lowc++;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 30 && exp_q.size() != 0; t++) @(negedge clock);
    check_val("drained", 32'(exp_q.size()), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1 reset = 1'b1;
    #2 check_val("reset_outputs",
                 {25'd0, Tx, tx_valid, tx_sof, tx_eof, in_ready, busy}, 0);
    #19 reset = 1'b0;                     // released between edges
    #1 check_val("ready_before_edge", 32'(in_ready), 0);
    @(negedge clock);
    check_val("ready_after_reset", 32'(in_ready), 1);
    check_val("busy_idle", 32'(busy), 0);

    // Impulse
    gap_cnt = 0;
    push_frame(4'b0001, FL + M, -1, 2'b00);
    send_frame(4'b0001, -1, 0, -1, 2'b00);
    finish_frame(low);
    check_val("impulse_ready_low", 32'(low), 3);
    drain();
    check_val("impulse_gaps", 32'(gap_cnt), 0);

    // Late one
    push_frame(4'b1000, FL + M, -1, 2'b00);
    send_frame(4'b1000, -1, 0, -1, 2'b00);
    finish_frame(low);
    check_val("late_ready_low", 32'(low), 3);
    drain();

    // Stall of two cycles after the first bit
    gap_cnt = 0;
    push_frame(4'b0001, FL + M, -1, 2'b00);
    send_frame(4'b0001, 0, 2, -1, 2'b00);
    finish_frame(low);
    drain();
    check_val("stall_gaps", 32'(gap_cnt), 2);

    // Back-to-back frames with in_valid held high
    run_cnt = 0;
    max_run = 0;
    hold_valid = 1'b1;
    push_frame(4'b0001, FL + M, -1, 2'b00);
    push_frame(4'b0001, FL + M, -1, 2'b00);
    send_frame(4'b0001, -1, 0, -1, 2'b00);
    send_frame(4'b0001, -1, 0, -1, 2'b00);
    hold_valid = 1'b0;
    finish_frame(low);
    check_val("b2b_ready_low", 32'(low), 3);
    drain();
    check_val("b2b_run", 32'(max_run), 2 * (FL + M));

    // Reset during the second tail cycle
    push_frame(4'b0001, FL + 1, -1, 2'b00);
    send_frame(4'b0001, -1, 0, -1, 2'b00);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1 check_val("midtail_reset_outputs",
                 {25'd0, Tx, tx_valid, tx_sof, tx_eof, in_ready, busy}, 0);
    check_val("midtail_consumed", 32'(exp_q.size()), 0);
    #10 reset = 1'b0;
    push_frame(4'b0001, FL + M, -1, 2'b00);
    send_frame(4'b0001, -1, 0, -1, 2'b00);
    finish_frame(low);
    check_val("after_reset_ready_low", 32'(low), 3);
    drain();

`ifdef CONV_ENC_ERR_INJECT_EN
    // Flip Tx[0] of symbol 2 only; encoder state must be unaffected.
    push_frame(4'b0001, FL + M, 1, 2'b01);
    send_frame(4'b0001, -1, 0, 1, 2'b01);
    finish_frame(low);
    drain();
`endif

    // Randomised frames with random stalls
    for (int f = 0; f < 16; f++) begin
      logic [FL-1:0] b;
      int            sp, sl;
      b  = FL'($urandom);
      sp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FL - 2)) : -1;
      sl = int'($urandom_range(1, 3));
      gap_cnt = 0;
      idle(0);
      push_frame(b, FL + M, -1, 2'b00);
      send_frame(b, sp, sl, -1, 2'b00);
      finish_frame(low);
      check_val("rand_ready_low", 32'(low), 3);
      drain();
      check_val("rand_gaps", 32'(gap_cnt), (sp >= 0) ? sl : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
